// File: rtl/pipe_perf_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding,
// read-select codes and channel-count bounds.
package pipe_perf_pkg;

  // Monitor control states
  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_RUN  = 2'd1,
    PM_DONE = 2'd2
  } pm_state_e;

  // Largest number of event channels the read map can address
  localparam int PM_MAX_EVT = 16;

  // Read-select codes above the event-counter window
  localparam logic [4:0] PM_SEL_CYC = 5'd16;
  localparam logic [4:0] PM_SEL_OVF = 5'd17;

  // True when a select code addresses an event channel that exists
  function automatic logic pm_sel_is_evt(input logic [4:0] sel, input int num_evt);
    return ({27'd0, sel} < num_evt);
  endfunction

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter with a sticky "increment dropped" flag.
// clr has priority over inc_en; at all-ones the value holds and the flag sets.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_en_i,
  output logic [CNT_W-1:0] value_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] value_d, value_q;
  logic             ovf_d, ovf_q;
  logic             at_max_s;

  // Next-state: clear, saturating increment, or hold
  always_comb begin
    at_max_s = &value_q;
    value_d  = value_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      value_d = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
    end else if (inc_en_i) begin
      if (at_max_s) begin
        value_d = value_q;
        ovf_d   = 1'b1;
      end else begin
        value_d = value_q + CNT_W'(1);
        ovf_d   = ovf_q;
      end
    end else begin
      value_d = value_q;
      ovf_d   = ovf_q;
    end
  end

  // Counter and flag state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Per-cycle event monitor: NUM_EVT saturating event counters plus a cycle
// counter under IDLE/RUN/DONE control, with a 1-cycle-latency read port.
// Optional feature macro: PERF_MON_SNAPSHOT_EN adds snap_i and a shadow bank
// selected by rd_sel_i[5].
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int NUM_EVT   = 4,
  parameter int CNT_W     = 32,
  parameter int CYC_LIMIT = 30
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] event_i,
`ifdef PERF_MON_SNAPSHOT_EN
  input  logic               snap_i,
  input  logic [5:0]         rd_sel_i,
`else
  input  logic [4:0]         rd_sel_i,
`endif
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT-1:0] ovf_o
);

  localparam logic             LIM_EN_C = (CYC_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(CYC_LIMIT);

  pm_state_e state_d, state_q;
  logic      running_d, running_q;
  logic      done_d, done_q;

  logic                 cnt_en_s;
  logic                 limit_hit_s;
  logic [CNT_W-1:0]     evt_cnt_s [NUM_EVT];
  logic [NUM_EVT-1:0]   evt_ovf_s;
  logic [CNT_W-1:0]     cyc_cnt_s;
  logic                 cyc_sat_s;

  logic [4:0]           sel_idx_s;
  logic [CNT_W-1:0]     src_evt_s [NUM_EVT];
  logic [CNT_W-1:0]     src_cyc_s;
  logic [NUM_EVT-1:0]   src_ovf_s;
  logic [CNT_W-1:0]     rd_data_d, rd_data_q;

  // Counting happens on every edge that starts in RUN; clear wins inside the counters.
  assign cnt_en_s = (state_q == PM_RUN);

  // Once the cycle counter has saturated, cyc+1 wraps and must not look like the limit.
  assign limit_hit_s = LIM_EN_C && !cyc_sat_s && ((cyc_cnt_s + CNT_W'(1)) == LIMIT_C);

  genvar g;
  generate
    for (g = 0; g < NUM_EVT; g++) begin : g_evt
      sat_counter #(.CNT_W(CNT_W)) u_evt_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clear_i),
        .inc_en_i (cnt_en_s & event_i[g]),
        .value_o  (evt_cnt_s[g]),
        .ovf_o    (evt_ovf_s[g])
      );
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clear_i),
    .inc_en_i (cnt_en_s),
    .value_o  (cyc_cnt_s),
    .ovf_o    (cyc_sat_s)
  );

  // FSM next state; clear beats limit beats start
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = PM_IDLE;
    end else begin
      case (state_q)
        PM_IDLE: begin
          if (start_i) state_d = PM_RUN;
          else         state_d = PM_IDLE;
        end
        PM_RUN: begin
          if (limit_hit_s)   state_d = PM_DONE;
          else if (!start_i) state_d = PM_IDLE;
          else               state_d = PM_RUN;
        end
        PM_DONE: state_d = PM_DONE;
        default: state_d = PM_IDLE;
      endcase
    end
    running_d = (state_d == PM_RUN);
    done_d    = (state_d == PM_DONE);
  end

  // FSM state and its registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= PM_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sel_idx_s = rd_sel_i[4:0];

`ifdef PERF_MON_SNAPSHOT_EN
  // The copy lands one edge after snap_i, taking the counters' post-snap-edge
  // values; in that gap a shadow read is served from the live counters.
  logic               snap_pend_q;
  logic [CNT_W-1:0]   shd_evt_d [NUM_EVT];
  logic [CNT_W-1:0]   shd_evt_q [NUM_EVT];
  logic [CNT_W-1:0]   shd_cyc_d, shd_cyc_q;
  logic [NUM_EVT-1:0] shd_ovf_d, shd_ovf_q;

  // Shadow bank next state: capture the live bank while a copy is pending
  always_comb begin
    for (int k = 0; k < NUM_EVT; k++) begin
      shd_evt_d[k] = snap_pend_q ? evt_cnt_s[k] : shd_evt_q[k];
    end
    shd_cyc_d = snap_pend_q ? cyc_cnt_s : shd_cyc_q;
    shd_ovf_d = snap_pend_q ? evt_ovf_s : shd_ovf_q;
  end

  // Shadow bank state; cleared by reset only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_pend_q <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_q[k] <= {CNT_W{1'b0}};
      shd_cyc_q   <= {CNT_W{1'b0}};
      shd_ovf_q   <= {NUM_EVT{1'b0}};
    end else begin
      snap_pend_q <= snap_i;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_q[k] <= shd_evt_d[k];
      shd_cyc_q   <= shd_cyc_d;
      shd_ovf_q   <= shd_ovf_d;
    end
  end

  // Read source: shadow bank (or its pending copy) when rd_sel_i[5] is set
  always_comb begin
    if (rd_sel_i[5] && !snap_pend_q) begin
      for (int k = 0; k < NUM_EVT; k++) src_evt_s[k] = shd_evt_q[k];
      src_cyc_s = shd_cyc_q;
      src_ovf_s = shd_ovf_q;
    end else begin
      for (int k = 0; k < NUM_EVT; k++) src_evt_s[k] = evt_cnt_s[k];
      src_cyc_s = cyc_cnt_s;
      src_ovf_s = evt_ovf_s;
    end
  end
`else
  // Read source: live counters only
  always_comb begin
    for (int k = 0; k < NUM_EVT; k++) src_evt_s[k] = evt_cnt_s[k];
    src_cyc_s = cyc_cnt_s;
    src_ovf_s = evt_ovf_s;
  end
`endif

  // Read mux; unmapped selects return zero, flags are zero-extended
  always_comb begin
    rd_data_d = {CNT_W{1'b0}};
    if (sel_idx_s == PM_SEL_CYC) begin
      rd_data_d = src_cyc_s;
    end else if (sel_idx_s == PM_SEL_OVF) begin
      rd_data_d = CNT_W'(src_ovf_s);
    end else if (pm_sel_is_evt(sel_idx_s, NUM_EVT)) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        rd_data_d = (sel_idx_s == 5'(k)) ? src_evt_s[k] : rd_data_d;
      end
    end else begin
      rd_data_d = {CNT_W{1'b0}};
    end
  end

  // Registered read data, one cycle behind the select
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= {CNT_W{1'b0}};
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
  assign cycle_o   = cyc_cnt_s;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign ovf_o     = evt_ovf_s;

endmodule
